// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin arbiter sharing one pipelined Wishbone slave bus between
// NUM_MASTERS Wishbone masters. A grant is registered and held for a whole
// master bus cycle plus any acks still outstanding, so every ack is routed
// back to the master that issued the transfer.
//
// Ports:
//   clk, aresetn         clock, asynchronous active-low reset
//   s_wb_*               per-master Wishbone slave ports (master i = slice i)
//   m_wb_*               shared Wishbone master port towards the slave
//   grant_valid          a master currently owns the bus
//   grant_idx            index of the owning (or most recently granted) master
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
   parameter int NUM_MASTERS      = 2,
   parameter int ADDR_BITS        = 8,
   parameter int BYTES            = 1,
   parameter int SEL_WIDTH        = 1,
   parameter int OUTSTANDING_BITS = 8
) (
   input  logic                                  clk,
   input  logic                                  aresetn,
   input  logic [NUM_MASTERS*ADDR_BITS-1:0]      s_wb_addr,
   input  logic [NUM_MASTERS*BYTES*8-1:0]        s_wb_dat_m2s,
   output logic [BYTES*8-1:0]                    s_wb_dat_s2m,
   input  logic [NUM_MASTERS-1:0]                s_wb_we,
   input  logic [NUM_MASTERS*SEL_WIDTH-1:0]      s_wb_sel,
   input  logic [NUM_MASTERS-1:0]                s_wb_stb,
   input  logic [NUM_MASTERS-1:0]                s_wb_cyc,
   output logic [NUM_MASTERS-1:0]                s_wb_ack,
   output logic [NUM_MASTERS-1:0]                s_wb_stall,
   output logic [ADDR_BITS-1:0]                  m_wb_addr,
   output logic [BYTES*8-1:0]                    m_wb_dat_m2s,
   input  logic [BYTES*8-1:0]                    m_wb_dat_s2m,
   output logic                                  m_wb_we,
   output logic [SEL_WIDTH-1:0]                  m_wb_sel,
   output logic                                  m_wb_stb,
   output logic                                  m_wb_cyc,
   input  logic                                  m_wb_ack,
   input  logic                                  m_wb_stall,
   output logic                                  grant_valid,
   output logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] grant_idx
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int DW    = BYTES * 8;

   typedef enum logic {
      IDLE,
      GRANTED
   } state_t;

   state_t                      state_q, state_d;
   logic [IDX_W-1:0]            grant_idx_q, grant_idx_d;
   logic [IDX_W-1:0]            last_grant_q, last_grant_d;
   logic [OUTSTANDING_BITS-1:0] outstanding_q, outstanding_d;

   logic [IDX_W-1:0]            rr_pick;
   logic                        rr_found;
   logic                        accept;
   int                          cand;

   // Round-robin search: first requester after the last granted master,
   // wrapping around, so the previous owner has the lowest priority.
   always_comb begin
      rr_pick  = '0;
      rr_found = 1'b0;
      cand     = 0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand = (int'(last_grant_q) + k) % NUM_MASTERS;
         if (!rr_found && s_wb_cyc[cand]) begin
            rr_found = 1'b1;
            rr_pick  = IDX_W'(cand);
         end
      end
   end

   // Bus steering. Outside a grant everything is parked low and every master
   // sees stall so nobody believes a transfer was taken. Gating stb with the
   // owner's cyc also forces stb low when the owner abandons its cycle while
   // acks are still due.
   always_comb begin
      m_wb_addr    = '0;
      m_wb_dat_m2s = '0;
      m_wb_we      = 1'b0;
      m_wb_sel     = '0;
      m_wb_stb     = 1'b0;
      m_wb_cyc     = 1'b0;
      s_wb_stall   = '1;
      s_wb_ack     = '0;
      if (state_q == GRANTED) begin
         m_wb_addr    = s_wb_addr[int'(grant_idx_q)*ADDR_BITS +: ADDR_BITS];
         m_wb_dat_m2s = s_wb_dat_m2s[int'(grant_idx_q)*DW +: DW];
         m_wb_we      = s_wb_we[grant_idx_q];
         m_wb_sel     = s_wb_sel[int'(grant_idx_q)*SEL_WIDTH +: SEL_WIDTH];
         m_wb_stb     = s_wb_stb[grant_idx_q] & s_wb_cyc[grant_idx_q];
         m_wb_cyc     = s_wb_cyc[grant_idx_q] | (outstanding_q != '0);
         s_wb_stall[grant_idx_q] = m_wb_stall;
         s_wb_ack[grant_idx_q]   = m_wb_ack;
      end
   end

   assign s_wb_dat_s2m = m_wb_dat_s2m;
   assign grant_valid  = (state_q == GRANTED);
   assign grant_idx    = grant_idx_q;
   assign accept       = m_wb_stb & ~m_wb_stall;

   // Next-state logic. The counter only moves while granted and never
   // underflows, so stray acks (in IDLE or with nothing pending) are harmless.
   // Release uses the post-update count so the final ack and the drop to IDLE
   // happen on the same edge.
   always_comb begin
      state_d       = state_q;
      grant_idx_d   = grant_idx_q;
      last_grant_d  = last_grant_q;
      outstanding_d = outstanding_q;
      if (state_q == GRANTED) begin
         if (accept && !m_wb_ack) begin
            outstanding_d = outstanding_q + OUTSTANDING_BITS'(1);
         end else if (m_wb_ack && !accept && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - OUTSTANDING_BITS'(1);
         end
         if (!s_wb_cyc[grant_idx_q] && (outstanding_d == '0)) begin
            state_d = IDLE;
         end
      end else if (rr_found) begin
         state_d      = GRANTED;
         grant_idx_d  = rr_pick;
         last_grant_d = rr_pick;
      end
   end

   // State register. last_grant resets to the highest index so master 0 is
   // the first one the round-robin search reaches.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q       <= IDLE;
         grant_idx_q   <= '0;
         last_grant_q  <= IDX_W'(NUM_MASTERS - 1);
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         grant_idx_q   <= grant_idx_d;
         last_grant_q  <= last_grant_d;
         outstanding_q <= outstanding_d;
      end
   end

endmodule
